// File: rtl/dino_obstacle_scheduler_if.sv
// Control and draw-list bundle between game control, the obstacle scheduler
// and the video renderer.
//   enable/start/escape/collision : game-level commands into the scheduler
//   state/speed                   : run state (0 IDLE, 1 RUN, 2 HALT) and scroll speed
//   cactus_x/cactus_h             : 4 cactus slots, 10-bit x and 2-bit height (0 = inactive)
//   bird_x/bird_y                 : 4 bird slots, 10-bit x and y (y 0 = inactive)
//   spawn_count                   : obstacles spawned in the current run, saturating
interface dino_obstacle_scheduler_if;
  logic        enable;
  logic        start;
  logic        escape;
  logic        collision;
  logic [1:0]  state;
  logic [3:0]  speed;
  logic [39:0] cactus_x;
  logic [7:0]  cactus_h;
  logic [39:0] bird_x;
  logic [39:0] bird_y;
  logic [15:0] spawn_count;

  // Game control side.
  modport master (
    output enable, start, escape, collision,
    input  state, speed, cactus_x, cactus_h, bird_x, bird_y, spawn_count
  );

  // Scheduler side.
  modport slave (
    input  enable, start, escape, collision,
    output state, speed, cactus_x, cactus_h, bird_x, bird_y, spawn_count
  );
endinterface

// File: rtl/dino_obstacle_scheduler.sv
// Per-frame obstacle scheduler for the dino game: owns 4 cactus and 4 bird
// slots, spawns obstacles at pseudo-random intervals, scrolls them left at a
// speed that rises over the run, and recycles slots that leave the screen.
// One clock edge is one game frame.
//   clock : frame clock
//   reset : asynchronous, active-low reset
//   bus   : command inputs and registered draw-list outputs (slave modport)
module dino_obstacle_scheduler #(
  parameter int unsigned SPAWN_X        = 800,
  parameter int unsigned OFFSCREEN      = 1023,
  parameter int unsigned MIN_GAP        = 40,
  parameter int unsigned INIT_SPEED     = 4,
  parameter int unsigned MAX_SPEED      = 12,
  parameter int unsigned SPEEDUP_PERIOD = 600,
  parameter int unsigned BIRD_Y_LOW     = 420,
  parameter int unsigned BIRD_Y_HIGH    = 360
) (
  input  logic                        clock,
  input  logic                        reset,
  dino_obstacle_scheduler_if.slave    bus
);

  localparam int unsigned N_SLOTS = 4;
  localparam int unsigned IW      = $clog2(N_SLOTS);
  localparam int unsigned XW      = 10;
  localparam int unsigned HW      = 2;
  localparam int unsigned SPW     = 4;
  localparam int unsigned CNTW    = 16;
  localparam int unsigned LFSRW   = 16;
  // Timer must hold MIN_GAP + a 6-bit random extension.
  localparam int unsigned TW      = $clog2(MIN_GAP + 64);
  localparam int unsigned FW      = $clog2(SPEEDUP_PERIOD + 1);

  localparam logic [XW-1:0]    X_OFF     = XW'(OFFSCREEN);
  localparam logic [XW-1:0]    X_SPAWN   = XW'(SPAWN_X);
  localparam logic [XW-1:0]    Y_LOW     = XW'(BIRD_Y_LOW);
  localparam logic [XW-1:0]    Y_HIGH    = XW'(BIRD_Y_HIGH);
  localparam logic [SPW-1:0]   SPD_INIT  = SPW'(INIT_SPEED);
  localparam logic [SPW-1:0]   SPD_MAX   = SPW'(MAX_SPEED);
  localparam logic [TW-1:0]    TMR_INIT  = TW'(MIN_GAP);
  localparam logic [FW-1:0]    FRM_LAST  = FW'(SPEEDUP_PERIOD - 1);
  localparam logic [LFSRW-1:0] LFSR_SEED = 16'hACE1;
  localparam logic [CNTW-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e                        state_q, state_d;
  logic [SPW-1:0]                speed_q, speed_d;
  logic [N_SLOTS-1:0][XW-1:0]    cx_q, cx_d;
  logic [N_SLOTS-1:0][HW-1:0]    ch_q, ch_d;
  logic [N_SLOTS-1:0][XW-1:0]    bx_q, bx_d;
  logic [N_SLOTS-1:0][XW-1:0]    by_q, by_d;
  logic [TW-1:0]                 timer_q, timer_d;
  logic [FW-1:0]                 frame_q, frame_d;
  logic [CNTW-1:0]               count_q, count_d;
  logic [LFSRW-1:0]              lfsr_q, lfsr_d;

  logic [IW-1:0] c_idx, b_idx;
  logic          c_any, b_any;
  logic          do_clear, do_step;
  logic          spawn_bird, spawn_cactus;

  // Lowest-index free slot per bank, from start-of-cycle occupancy so a slot
  // retired this frame cannot be reused until the next one.
  always_comb begin
    c_idx = '0;
    b_idx = '0;
    c_any = 1'b0;
    b_any = 1'b0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (ch_q[i] == '0) begin
        c_idx = IW'(i);
        c_any = 1'b1;
      end
      if (by_q[i] == '0) begin
        b_idx = IW'(i);
        b_any = 1'b1;
      end
    end
  end

  // Command decode, next state and per-frame datapath update.
  always_comb begin
    state_d      = state_q;
    speed_d      = speed_q;
    cx_d         = cx_q;
    ch_d         = ch_q;
    bx_d         = bx_q;
    by_d         = by_q;
    timer_d      = timer_q;
    frame_d      = frame_q;
    count_d      = count_q;
    lfsr_d       = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[LFSRW-1:1]};
    do_clear     = 1'b0;
    do_step      = 1'b0;
    spawn_bird   = 1'b0;
    spawn_cactus = 1'b0;

    if (bus.enable) begin
      if (bus.escape) begin
        state_d  = ST_IDLE;
        do_clear = 1'b1;
      end else if (bus.collision && (state_q == ST_RUN)) begin
        state_d = ST_HALT;
      end else if (bus.start && (state_q != ST_RUN)) begin
        state_d  = ST_RUN;
        do_clear = 1'b1;
      end else if (state_q == ST_RUN) begin
        do_step = 1'b1;
      end
    end

    if (do_clear) begin
      cx_d    = {N_SLOTS{X_OFF}};
      ch_d    = '0;
      bx_d    = {N_SLOTS{X_OFF}};
      by_d    = '0;
      speed_d = SPD_INIT;
      timer_d = TMR_INIT;
      frame_d = '0;
      count_d = '0;
    end

    if (do_step) begin
      // Scroll active slots; anything that would reach x <= 0 retires instead.
      for (int i = 0; i < N_SLOTS; i++) begin
        if (ch_q[i] != '0) begin
          if (cx_q[i] > XW'(speed_q)) begin
            cx_d[i] = cx_q[i] - XW'(speed_q);
          end else begin
            cx_d[i] = X_OFF;
            ch_d[i] = '0;
          end
        end
        if (by_q[i] != '0) begin
          if (bx_q[i] > XW'(speed_q)) begin
            bx_d[i] = bx_q[i] - XW'(speed_q);
          end else begin
            bx_d[i] = X_OFF;
            by_d[i] = '0;
          end
        end
      end

      // Spawn when the timer has run out; both banks full leaves timer at 0.
      if (timer_q != '0) begin
        timer_d = timer_q - TW'(1);
      end else begin
        spawn_bird   = b_any && (lfsr_q[7] || !c_any);
        spawn_cactus = c_any && !spawn_bird;
        if (spawn_bird) begin
          bx_d[b_idx] = X_SPAWN;
          by_d[b_idx] = lfsr_q[8] ? Y_HIGH : Y_LOW;
        end
        if (spawn_cactus) begin
          cx_d[c_idx] = X_SPAWN;
          ch_d[c_idx] = (lfsr_q[1:0] == 2'd0) ? 2'd1 : lfsr_q[1:0];
        end
        if (spawn_bird || spawn_cactus) begin
          timer_d = TMR_INIT + TW'(lfsr_q[5:0]);
          count_d = (count_q == CNT_MAX) ? count_q : count_q + CNTW'(1);
        end
      end

      // Speed ramp: one increment per full period, capped.
      if (frame_q == FRM_LAST) begin
        frame_d = '0;
        if (speed_q < SPD_MAX) begin
          speed_d = speed_q + SPW'(1);
        end
      end else begin
        frame_d = frame_q + FW'(1);
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      speed_q <= SPD_INIT;
      cx_q    <= {N_SLOTS{X_OFF}};
      ch_q    <= '0;
      bx_q    <= {N_SLOTS{X_OFF}};
      by_q    <= '0;
      timer_q <= TMR_INIT;
      frame_q <= '0;
      count_q <= '0;
      lfsr_q  <= LFSR_SEED;
    end else begin
      state_q <= state_d;
      speed_q <= speed_d;
      cx_q    <= cx_d;
      ch_q    <= ch_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      timer_q <= timer_d;
      frame_q <= frame_d;
      count_q <= count_d;
      lfsr_q  <= lfsr_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.speed       = speed_q;
  assign bus.cactus_x    = cx_q;
  assign bus.cactus_h    = ch_q;
  assign bus.bird_x      = bx_q;
  assign bus.bird_y      = by_q;
  assign bus.spawn_count = count_q;

endmodule

// File: tb/tb_dino_obstacle_scheduler.sv
// Bench for dino_obstacle_scheduler: a default instance plus a slow (speed 1)
// instance whose long-lived obstacles fill both banks and force deferred spawns.
module tb_dino_obstacle_scheduler;

  localparam int SPAWN_X = 800;
  localparam int OFF     = 1023;
  localparam int GAP     = 40;
  localparam int PERIOD  = 600;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic start = 1'b0;
  logic escape = 1'b0;
  logic collision = 1'b0;

  always #5 clock = ~clock;

  dino_obstacle_scheduler_if bus0();
  dino_obstacle_scheduler_if bus1();

  assign bus0.enable = enable;
  assign bus0.start = start;
  assign bus0.escape = escape;
  assign bus0.collision = collision;
  assign bus1.enable = enable;
  assign bus1.start = start;
  assign bus1.escape = escape;
  assign bus1.collision = collision;

  dino_obstacle_scheduler u_dut0 (.clock(clock), .reset(reset), .bus(bus0));
  dino_obstacle_scheduler #(.INIT_SPEED(1), .MAX_SPEED(1)) u_dut1 (.clock(clock), .reset(reset), .bus(bus1));

  int checks = 0;
  int passed = 0;

  // Model: slots 0..3 are cacti, 4..7 birds; attr is height or y, 0 = empty.
  int m_state[2], m_speed[2], m_timer[2], m_frame[2], m_count[2], m_lfsr[2];
  int m_x[2][8];
  int m_a[2][8];
  int p_init[2] = '{4, 1};
  int p_max[2]  = '{12, 1};
  bit pending[2] = '{0, 0};
  bit defer_then_spawn[2] = '{0, 0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic m_clear(input int k);
    for (int s = 0; s < 8; s++) begin
      m_x[k][s] = OFF;
      m_a[k][s] = 0;
    end
    m_speed[k] = p_init[k];
    m_timer[k] = GAP;
    m_frame[k] = 0;
    m_count[k] = 0;
  endtask

  task automatic m_reset(input int k);
    m_clear(k);
    m_state[k] = 0;
    m_lfsr[k] = 16'hACE1;
    pending[k] = 1'b0;
  endtask

  task automatic m_step(input int k);
    int l, fb, slot, pref, bank, h;
    int ox[8];
    int oa[8];
    l = m_lfsr[k];
    for (int s = 0; s < 8; s++) begin
      ox[s] = m_x[k][s];
      oa[s] = m_a[k][s];
    end
    if (enable) begin
      if (escape) begin
        m_clear(k);
        m_state[k] = 0;
      end else if (collision && m_state[k] == 1) begin
        m_state[k] = 2;
      end else if (start && m_state[k] != 1) begin
        m_clear(k);
        m_state[k] = 1;
      end else if (m_state[k] == 1) begin
        for (int s = 0; s < 8; s++) begin
          if (oa[s] != 0) begin
            if (ox[s] > m_speed[k]) m_x[k][s] = ox[s] - m_speed[k];
            else begin
              m_x[k][s] = OFF;
              m_a[k][s] = 0;
            end
          end
        end
        if (m_timer[k] > 0) m_timer[k]--;
        else begin
          pref = (l >> 7) & 1;
          slot = -1;
          for (int t = 0; t < 2; t++) begin
            bank = (t == 0) ? pref : 1 - pref;
            for (int j = 0; j < 4; j++)
              if (slot < 0 && oa[bank * 4 + j] == 0) slot = bank * 4 + j;
          end
          if (slot < 0) pending[k] = 1'b1;
          else begin
            m_x[k][slot] = SPAWN_X;
            if (slot < 4) begin
              h = l & 3;
              m_a[k][slot] = (h == 0) ? 1 : h;
            end else begin
              m_a[k][slot] = ((l >> 8) & 1) ? 360 : 420;
            end
            m_timer[k] = GAP + (l & 63);
            if (m_count[k] < 65535) m_count[k]++;
            if (pending[k]) defer_then_spawn[k] = 1'b1;
            pending[k] = 1'b0;
          end
        end
        if (m_frame[k] == PERIOD - 1) begin
          m_frame[k] = 0;
          if (m_speed[k] < p_max[k]) m_speed[k]++;
        end else m_frame[k]++;
      end
    end
    fb = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
    m_lfsr[k] = (l >> 1) | (fb << 15);
  endtask

  task automatic cmp(input int k);
    logic [39:0] ecx, ebx, eby, acx, abx, aby;
    logic [7:0] ech, ach;
    logic [1:0] ast;
    logic [3:0] asp;
    logic [15:0] acn;
    for (int i = 0; i < 4; i++) begin
      ecx[10*i +: 10] = 10'(m_x[k][i]);
      ech[2*i +: 2]   = 2'(m_a[k][i]);
      ebx[10*i +: 10] = 10'(m_x[k][4+i]);
      eby[10*i +: 10] = 10'(m_a[k][4+i]);
    end
    if (k == 0) begin
      ast = bus0.state; asp = bus0.speed; acx = bus0.cactus_x; ach = bus0.cactus_h;
      abx = bus0.bird_x; aby = bus0.bird_y; acn = bus0.spawn_count;
    end else begin
      ast = bus1.state; asp = bus1.speed; acx = bus1.cactus_x; ach = bus1.cactus_h;
      abx = bus1.bird_x; aby = bus1.bird_y; acn = bus1.spawn_count;
    end
    chk($sformatf("dut%0d state", k), 64'(ast), 64'(m_state[k]));
    chk($sformatf("dut%0d speed", k), 64'(asp), 64'(m_speed[k]));
    chk($sformatf("dut%0d cactus_x", k), 64'(acx), 64'(ecx));
    chk($sformatf("dut%0d cactus_h", k), 64'(ach), 64'(ech));
    chk($sformatf("dut%0d bird_x", k), 64'(abx), 64'(ebx));
    chk($sformatf("dut%0d bird_y", k), 64'(aby), 64'(eby));
    chk($sformatf("dut%0d spawn_count", k), 64'(acn), 64'(m_count[k]));
  endtask

  // Model update on every edge, then compare once outputs have settled.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_reset(0);
      m_reset(1);
    end else begin
      m_step(0);
      m_step(1);
    end
    #1;
    cmp(0);
    cmp(1);
  end

  function automatic logic [9:0] slot_x(input int s);
    if (s < 4) return bus0.cactus_x[10*s +: 10];
    return bus0.bird_x[10*(s-4) +: 10];
  endfunction

  function automatic logic [9:0] slot_attr(input int s);
    if (s < 4) return 10'(bus0.cactus_h[2*s +: 2]);
    return bus0.bird_y[10*(s-4) +: 10];
  endfunction

  task automatic check_cleared(input string tag);
    logic [39:0] all_off;
    all_off = {4{10'd1023}};
    chk({tag, " speed"}, 64'(bus0.speed), 64'd4);
    chk({tag, " cactus_x"}, 64'(bus0.cactus_x), 64'(all_off));
    chk({tag, " bird_x"}, 64'(bus0.bird_x), 64'(all_off));
    chk({tag, " cactus_h"}, 64'(bus0.cactus_h), 64'd0);
    chk({tag, " bird_y"}, 64'(bus0.bird_y), 64'd0);
    chk({tag, " spawn_count"}, 64'(bus0.spawn_count), 64'd0);
  endtask

  initial begin
    int first_slot, n800;
    repeat (3) @(negedge clock);
    chk("reset state", 64'(bus0.state), 64'd0);
    check_cleared("reset");
    reset = 1'b1;

    // Start pulse; the entry edge neither moves nor spawns.
    @(negedge clock);
    enable = 1'b1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("start state", 64'(bus0.state), 64'd1);
    repeat (40) @(negedge clock);
    chk("no spawn by run 40", 64'(bus0.spawn_count), 64'd0);
    @(negedge clock);
    chk("first spawn count", 64'(bus0.spawn_count), 64'd1);
    n800 = 0;
    first_slot = 0;
    for (int s = 0; s < 8; s++) begin
      if (slot_x(s) == 10'd800) n800++;
      if (m_x[0][s] == SPAWN_X) first_slot = s;
    end
    chk("slots at 800", 64'(n800), 64'd1);
    @(negedge clock);
    chk("first move", 64'(slot_x(first_slot)), 64'd796);
    repeat (198) @(negedge clock);
    chk("slot at 4", 64'(slot_x(first_slot)), 64'd4);
    @(negedge clock);
    chk("retired x", 64'(slot_x(first_slot)), 64'd1023);
    chk("retired attr", 64'(slot_attr(first_slot)), 64'd0);

    // Speed ramp: first increment after 600 run frames.
    repeat (358) @(negedge clock);
    chk("speed at 599", 64'(bus0.speed), 64'd4);
    @(negedge clock);
    chk("speed at 600", 64'(bus0.speed), 64'd5);

    enable = 1'b0;
    repeat (20) @(negedge clock);
    enable = 1'b1;
    repeat (4300) @(negedge clock);
    chk("speed at 4900", 64'(bus0.speed), 64'd12);
    repeat (700) @(negedge clock);
    chk("speed saturated", 64'(bus0.speed), 64'd12);

    // Collision freezes; further collisions in HALT are ignored.
    collision = 1'b1;
    @(negedge clock);
    chk("halt state", 64'(bus0.state), 64'd2);
    repeat (100) @(negedge clock);
    collision = 1'b0;
    chk("still halted", 64'(bus0.state), 64'd2);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("restart state", 64'(bus0.state), 64'd1);
    check_cleared("restart");

    repeat (60) @(negedge clock);
    escape = 1'b1;
    start = 1'b1;
    @(negedge clock);
    escape = 1'b0;
    start = 1'b0;
    chk("escape state", 64'(bus0.state), 64'd0);
    check_cleared("escape");

    // Asynchronous reset in the middle of a run.
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (50) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("async reset state", 64'(bus0.state), 64'd0);
    check_cleared("async reset");
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);

    chk("deferred spawn seen", 64'(defer_then_spawn[1]), 64'd1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/dino_obstacle_scheduler.md
Name: dino_obstacle_scheduler

Overview:
Per-frame obstacle scheduler for the dino game.
- Owns the 4 cactus slots and 4 bird slots that the video block draws.
- Spawns obstacles at pseudo-random intervals, scrolls them left at a rising speed and recycles slots once they leave the screen.
- Sits between game-level control (start/escape/collision) and the video renderer; one `clock` edge is one game frame.

Parameters:
SPAWN_X, 800, x coordinate given to a newly spawned obstacle
OFFSCREEN, 1023, x value reported for an inactive slot
MIN_GAP, 40, minimum frames between spawns
INIT_SPEED, 4, pixels per frame at run start
MAX_SPEED, 12, speed ceiling
SPEEDUP_PERIOD, 600, frames between speed increments
BIRD_Y_LOW, 420, bird y when lfsr[8]=0
BIRD_Y_HIGH, 360, bird y when lfsr[8]=1

Ports:
clock  in  1  frame clock
reset  in  1  asynchronous, active-low reset
enable  in  1  advance game state this cycle
start  in  1  begin a run from IDLE or HALT
escape  in  1  abort to IDLE
collision  in  1  player hit an obstacle
state  out  2  0=IDLE, 1=RUN, 2=HALT
speed  out  4  current scroll speed
cactus_x  out  40  4x10-bit packed; slot i at [10i+9:10i]
cactus_h  out  8  4x2-bit packed; 0=inactive, 1..3=height
bird_x  out  40  4x10-bit packed
bird_y  out  40  4x10-bit packed
spawn_count  out  16  obstacles spawned this run, saturating at 16'hFFFF

Behaviour:
- Reset, asynchronous on reset=0:
  - state=IDLE, speed=INIT_SPEED, spawn_count=0.
  - All x outputs = OFFSCREEN, cactus_h=0, bird_y=0.
  - LFSR=16'hACE1, spawn timer=MIN_GAP, frame counter=0.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Shifts every clock after reset, independent of `enable` and `state`.
- Command priority (evaluated only when enable=1):
  - escape > collision > start.
  - With enable=0, everything except the LFSR holds.
- escape: any state -> IDLE; all slots cleared to reset values; speed, timer and counters reinitialised.
- collision: RUN -> HALT. HALT freezes every output; collision is ignored in IDLE/HALT.
- start: IDLE or HALT -> RUN. On entry:
  - All slots cleared; speed=INIT_SPEED; timer=MIN_GAP.
  - frame counter=0; spawn_count=0.
  - No movement or spawn occurs on the entry cycle.
  - start while already in RUN is ignored.
- Each RUN cycle with enable=1, in this order using start-of-cycle values:
  - Move: every active slot with x > speed gets x -= speed. An active slot with x <= speed is deactivated (x=OFFSCREEN; cactus_h=0 or bird_y=0). A slot freed this way is not reusable until the next cycle.
  - Spawn timer:
    - If timer > 0, decrement it.
    - If timer == 0, attempt a spawn. The preferred bank is bird when lfsr[7]=1, otherwise cactus.
    - Use the lowest-index free slot of the preferred bank; if that bank is full, use the other bank; if both are full, defer (timer stays 0 and the spawn is retried next cycle).
    - The spawned slot gets x=SPAWN_X and is not moved that cycle.
    - A cactus gets h = lfsr[1:0], with 0 mapped to 1.
    - A bird gets bird_y per lfsr[8].
    - On a successful spawn: timer reloads to MIN_GAP + lfsr[5:0], and spawn_count increments.
  - Speed:
    - frame counter increments.
    - When it reaches SPEEDUP_PERIOD-1, it wraps to 0 and speed increments, saturating at MAX_SPEED.
- Outputs are registered; a change is visible one clock after the causing edge.
- x arithmetic is 10-bit unsigned and never wraps, because of the x <= speed retirement rule.

Test Plan:
- Reset -> state=0, speed=4, every x=1023, cactus_h=0, spawn_count=0; assert reset mid-RUN -> same values immediately, without waiting for a clock edge.
- start pulse, enable=1 held -> state=1; first spawn lands on the 41st RUN cycle, with exactly one slot at x=800 and spawn_count=1; that slot reads 796 on the following cycle.
- Obstacle at x=4, speed=4 -> next cycle x=1023 and h/y=0; same-cycle spawn with all other slots full goes to the other bank, or is deferred if both banks are full.
- Force a spawn with all 8 slots active -> timer holds 0 and no slot changes; a slot frees at cycle N and the spawn occurs at cycle N+1.
- 600 RUN frames -> speed 4->5; 4800+ frames -> speed saturates at 12 and goes no higher.
- collision in RUN -> state=2, outputs frozen for 100 cycles; start -> state=1 with all slots cleared; escape asserted together with start -> state=0.
